axil_reg_master: RTL and testbench

AXI4-Lite master that turns single register-access commands into AXI4-Lite read or write transactions. It is the initiating end of the slave register interface used by the system-control blocks. Host or sequencer logic drives a command/response handshake; the block runs the AW/W/B or AR/R channel protocol, captures the response, and reports timeouts.

---
 rtl/axil_reg_master.sv | 209 ++++++++++++++++++++
 tb/tb_axil_reg_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_master.sv
// AXI4-Lite register master: turns single command/response transactions into
// AW/W/B or AR/R channel traffic with a per-transaction timeout.
module axil_reg_master #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [15:0] timeout_count,

    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [2:0]  M_AXI_AWPROT,

    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,

    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,

    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [2:0]  M_AXI_ARPROT,

    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TCW = 16;

    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   tcnt, tcnt_d;
    logic [AW-1:0]   addr, addr_d;
    logic [DW-1:0]   wdata, wdata_d;
    logic [SW-1:0]   wstrb, wstrb_d;
    logic            cmd_ready_d;
    logic            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic            rsp_valid_d, rsp_timeout_d;
    logic [DW-1:0]   rsp_rdata_d;
    logic [1:0]      rsp_resp_d;
    logic [TCW-1:0]  timeout_count_d;
    logic            expired, b_hs, r_hs;

    // One latched address serves both channels; only one transaction is ever in flight.
    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARADDR = addr;
    assign M_AXI_WDATA  = wdata;
    assign M_AXI_WSTRB  = wstrb;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    assign expired = (tcnt == CW'(TIMEOUT - 1));
    assign b_hs    = M_AXI_BVALID & M_AXI_BREADY;
    assign r_hs    = M_AXI_RVALID & M_AXI_RREADY;

    // Next-state and next-output logic
    always_comb begin
        state_d         = state;
        tcnt_d          = tcnt;
        addr_d          = addr;
        wdata_d         = wdata;
        wstrb_d         = wstrb;
        cmd_ready_d     = cmd_ready;
        awvalid_d       = M_AXI_AWVALID;
        wvalid_d        = M_AXI_WVALID;
        bready_d        = M_AXI_BREADY;
        arvalid_d       = M_AXI_ARVALID;
        rready_d        = M_AXI_RREADY;
        rsp_valid_d     = rsp_valid;
        rsp_timeout_d   = rsp_timeout;
        rsp_rdata_d     = rsp_rdata;
        rsp_resp_d      = rsp_resp;
        timeout_count_d = timeout_count;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d      = cmd_addr;
                    tcnt_d      = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD;
                    end
                end
            end

            WR, RD: begin
                // Address/data channels retire independently of each other and of B/R
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (M_AXI_ARREADY) arvalid_d = 1'b0;

                if (b_hs || r_hs) begin
                    awvalid_d     = 1'b0;
                    wvalid_d      = 1'b0;
                    bready_d      = 1'b0;
                    arvalid_d     = 1'b0;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_resp_d    = b_hs ? M_AXI_BRESP : M_AXI_RRESP;
                    rsp_rdata_d   = b_hs ? '0 : M_AXI_RDATA;
                    state_d       = RSP;
                end else if (expired) begin
                    awvalid_d     = 1'b0;
                    wvalid_d      = 1'b0;
                    bready_d      = 1'b0;
                    arvalid_d     = 1'b0;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_resp_d    = 2'b10;
                    rsp_rdata_d   = '0;
                    if (timeout_count != '1)
                        timeout_count_d = timeout_count + TCW'(1);
                    state_d       = RSP;
                end else begin
                    tcnt_d = tcnt + CW'(1);
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tcnt          <= '0;
            addr          <= '0;
            wdata         <= '0;
            wstrb         <= '0;
            cmd_ready     <= 1'b1;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_timeout   <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_d;
            tcnt          <= tcnt_d;
            addr          <= addr_d;
            wdata         <= wdata_d;
            wstrb         <= wstrb_d;
            cmd_ready     <= cmd_ready_d;
            M_AXI_AWVALID <= awvalid_d;
            M_AXI_WVALID  <= wvalid_d;
            M_AXI_BREADY  <= bready_d;
            M_AXI_ARVALID <= arvalid_d;
            M_AXI_RREADY  <= rready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_timeout   <= rsp_timeout_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            timeout_count <= timeout_count_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_master.sv
// Randomised bench for axil_reg_master: a scripted AXI slave with its own memory,
// a reference register model and a response scoreboard.
module tb_axil_reg_master;

    localparam int TO = 16;
    localparam int CW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [15:0] timeout_count;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

    always #5 clk = ~clk;

    axil_reg_master #(.TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .timeout_count(timeout_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // d1: AW/AR ready delay, d2: W ready delay, d3: B/R valid delay (cycles from issue)
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          d1;
        int          d2;
        int          d3;
        bit          silent;
        logic [1:0]  resp;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        logic [15:0] tcount;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] mem_m [8];
    logic [31:0] smem  [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          force_hold = 0;
    bit          slave_busy = 1'b0;
    logic [15:0] exp_tcount = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic plan_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int d1, input int d2, input int d3,
                                 input bit sil, input logic [1:0] rsp);
        plan_t p;
        p.write = w;  p.addr = a;  p.wdata = d;  p.strb = s;
        p.d1 = d1;    p.d2 = d2;   p.d3 = d3;    p.silent = sil;  p.resp = rsp;
        return p;
    endfunction

    // Slave side of one transaction, one iteration per cycle starting at the issue cycle
    task automatic run_slave(input plan_t p);
        int          k = 0;
        int          b1 = 0;
        int          b2 = 0;
        bit          hs = 1'b0;
        bit          applied = 1'b0;
        bit          tmo = p.silent || (p.d3 > TO - 1);
        logic [31:0] aw_seen = '0;
        logic [31:0] w_seen = '0;
        logic [3:0]  s_seen = '0;
        while (1'b1) begin
            if (reset) break;
            if (p.write) begin
                if (M_AXI_AWVALID) check("awaddr", M_AXI_AWADDR, p.addr);
                if (M_AXI_WVALID) begin
                    check("wdata", M_AXI_WDATA, p.wdata);
                    check("wstrb", 32'(M_AXI_WSTRB), 32'(p.strb));
                end
                M_AXI_AWREADY = (k >= p.d1);
                M_AXI_WREADY  = (k >= p.d2);
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin b1++; aw_seen = M_AXI_AWADDR; end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    b2++; w_seen = M_AXI_WDATA; s_seen = M_AXI_WSTRB;
                end
                if (b1 > 0 && b2 > 0 && !applied) begin
                    smem[aw_seen[4:2]] = merge(smem[aw_seen[4:2]], w_seen, s_seen);
                    applied = 1'b1;
                end
                M_AXI_BVALID = !p.silent && (k >= p.d3);
                M_AXI_BRESP  = p.resp;
                hs = M_AXI_BVALID && M_AXI_BREADY;
                if (tmo && k == TO - 1) check("bready before expiry", 32'(M_AXI_BREADY), 1);
                if (tmo && k >= TO)     check("bready after expiry", 32'(M_AXI_BREADY), 0);
            end else begin
                if (M_AXI_ARVALID) check("araddr", M_AXI_ARADDR, p.addr);
                M_AXI_ARREADY = (k >= p.d1);
                if (M_AXI_ARVALID && M_AXI_ARREADY) b1++;
                M_AXI_RVALID = !p.silent && (b1 > 0) && (k >= p.d3);
                M_AXI_RDATA  = smem[p.addr[4:2]];
                M_AXI_RRESP  = p.resp;
                hs = M_AXI_RVALID && M_AXI_RREADY;
                if (tmo && k == TO - 1) check("rready before expiry", 32'(M_AXI_RREADY), 1);
                if (tmo && k >= TO)     check("rready after expiry", 32'(M_AXI_RREADY), 0);
            end
            if (tmo && k == TO)
                check("axi idle at expiry", {27'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                             M_AXI_ARVALID, M_AXI_RREADY}, 0);
            if (hs || k >= TO + 2) break;
            @(negedge clk);
            k++;
        end
        if (hs) @(negedge clk);
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        if (!reset) begin
            if (p.write) begin
                check("aw beats", 32'(b1), 1);
                check("w beats", 32'(b2), 1);
            end else begin
                check("ar beats", 32'(b1), 1);
            end
        end
    endtask

    // Slave process
    initial begin
        plan_t p;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;    M_AXI_RRESP = 2'b00;
        for (int i = 0; i < 8; i++) smem[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID)) begin
                if (plan_q.size() == 0) begin
                    check("axi request without command", 0, 1);
                end else begin
                    p = plan_q.pop_front();
                    slave_busy = 1'b1;
                    run_slave(p);
                    slave_busy = 1'b0;
                end
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        bit          held;
        bit          post;
        int          wait_left;
        exp_t        e;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        logic        s_to;
        held = 1'b0; post = 1'b0; wait_left = 0;
        s_rdata = '0; s_resp = '0; s_to = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0; post = 1'b0; rsp_ready = 1'b0;
            end else begin
                if (post) begin
                    check("cmd_ready after rsp", 32'(cmd_ready), 1);
                    check("rsp_valid after rsp", 32'(rsp_valid), 0);
                    post = 1'b0;
                end
                if (rsp_valid) begin
                    check("cmd_ready during rsp", 32'(cmd_ready), 0);
                    if (!held) begin
                        held = 1'b1;
                        s_rdata = rsp_rdata; s_resp = rsp_resp; s_to = rsp_timeout;
                        wait_left = (force_hold > 0) ? force_hold : int'($urandom_range(0, 3));
                        force_hold = 0;
                    end else begin
                        check("rsp_rdata stable", rsp_rdata, s_rdata);
                        check("rsp_resp stable", 32'(rsp_resp), 32'(s_resp));
                        check("rsp_timeout stable", 32'(rsp_timeout), 32'(s_to));
                    end
                    if (wait_left == 0) begin
                        rsp_ready = 1'b1;
                        if (exp_q.size() == 0) begin
                            check("response without command", 0, 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_rdata", rsp_rdata, e.rdata);
                            check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                            check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                            check("timeout_count", 32'(timeout_count), 32'(e.tcount));
                        end
                        held = 1'b0;
                        post = 1'b1;
                    end else begin
                        rsp_ready = 1'b0;
                        wait_left--;
                    end
                end else begin
                    rsp_ready = 1'b0;
                end
            end
        end
    end

    // Issue one command and record what the register model says must come back
    task automatic issue(input plan_t p, input int hold);
        int   w = 0;
        exp_t e;
        bit   tmo;
        while (!(cmd_ready && !slave_busy) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            check("cmd_ready wait expired", 0, 1);
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        force_hold = hold;
        tmo = p.silent || (p.d3 > TO - 1);
        if (p.write) mem_m[p.addr[4:2]] = merge(mem_m[p.addr[4:2]], p.wdata, p.strb);
        e.rdata = (tmo || p.write) ? 32'h0 : mem_m[p.addr[4:2]];
        e.resp  = tmo ? 2'b10 : p.resp;
        e.tmo   = tmo;
        if (tmo && exp_tcount != 16'hFFFF) exp_tcount = exp_tcount + 16'd1;
        e.tcount = exp_tcount;
        plan_q.push_back(p);
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = p.write;
        cmd_addr  = p.addr;
        cmd_wdata = p.wdata;
        cmd_wstrb = p.strb;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready after accept", 32'(cmd_ready), 0);
        check("issue valids", {27'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                               M_AXI_ARVALID, M_AXI_RREADY},
              p.write ? 32'h1C : 32'h03);
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        int    m;
        int    r;
        p.write  = 1'($urandom_range(0, 1));
        p.addr   = 32'($urandom_range(0, 7)) << 2;
        p.wdata  = $urandom;
        p.strb   = 4'($urandom_range(0, 15));
        p.d1     = int'($urandom_range(0, 5));
        p.d2     = int'($urandom_range(0, 5));
        p.resp   = 2'($urandom_range(0, 3));
        p.silent = 1'b0;
        m = (p.write && p.d2 > p.d1) ? p.d2 : p.d1;
        r = int'($urandom_range(0, 9));
        if (r == 0)      begin p.silent = 1'b1; p.d3 = 0; end
        else if (r == 1) p.d3 = int'($urandom_range(TO - 2, TO + 1));
        else             p.d3 = m + 1 + int'($urandom_range(0, 4));
        return p;
    endfunction

    // Stimulus
    initial begin
        plan_t p;
        int    w;
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready), 1);
        check("reset axi valids", {27'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                   M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("reset rsp", {28'b0, rsp_valid, rsp_timeout, rsp_resp}, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset timeout_count", 32'(timeout_count), 0);
        check("reset awaddr", M_AXI_AWADDR, 0);
        check("reset wdata", M_AXI_WDATA, 0);
        check("axprot", {26'b0, M_AXI_AWPROT, M_AXI_ARPROT}, 0);
        @(negedge clk);
        reset = 1'b0;

        issue(mk(1, 32'h8,  32'h1234_5678, 4'hF, 0, 0, 2, 0, 2'd0), 0);
        issue(mk(1, 32'hC,  32'hCAFE_F00D, 4'h5, 4, 1, 6, 0, 2'd1), 0);
        issue(mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, 3, 0, 2'd0), 0);
        issue(mk(0, 32'h10, 32'h0, 4'h0, 0, 0, 5, 0, 2'd3), 0);
        issue(mk(1, 32'h4,  32'hA5A5_A5A5, 4'h3, 0, 0, 0, 1, 2'd0), 0);
        issue(mk(0, 32'h8,  32'h0, 4'h0, 0, 0, 2, 0, 2'd0), 0);
        issue(mk(1, 32'h0,  32'h0BAD_F00D, 4'hC, 0, 0, TO - 1, 0, 2'd2), 0);
        issue(mk(0, 32'h4,  32'h0, 4'h0, 0, 0, TO, 0, 2'd0), 0);
        issue(mk(0, 32'hC,  32'h0, 4'h0, 1, 0, 3, 0, 2'd1), 10);

        for (int t = 0; t < 60; t++) issue(rand_plan(), 0);

        // Reset while a read address is still pending
        issue(mk(0, 32'h14, 32'h0, 4'h0, 8, 0, 12, 0, 2'd1), 0);
        repeat (2) @(negedge clk);
        check("arvalid before reset", 32'(M_AXI_ARVALID), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arvalid in reset", 32'(M_AXI_ARVALID), 0);
        check("rready in reset", 32'(M_AXI_RREADY), 0);
        check("rsp_valid in reset", 32'(rsp_valid), 0);
        check("cmd_ready in reset", 32'(cmd_ready), 1);
        exp_q.delete();
        plan_q.delete();
        exp_tcount = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready after reset", 32'(cmd_ready), 1);
        check("timeout_count after reset", 32'(timeout_count), 0);

        for (int t = 0; t < 8; t++) issue(rand_plan(), 0);

        w = 0;
        while ((exp_q.size() != 0 || slave_busy) && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard drained", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
